// File: rtl/alu_op_sequencer_pkg.sv
// Shared constants for the ALU op sequencer.
// Opcodes, command codes and FSM state encoding.
package alu_op_sequencer_pkg;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_XOR  = 3'b011;
  localparam logic [2:0] ALU_SLLI = 3'b100;
  localparam logic [2:0] ALU_ROR  = 3'b101;
  localparam logic [2:0] ALU_SUB  = 3'b110;

  localparam logic [3:0] CMD_MUL  = 4'b1000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_MUL_IT,
    S_DONE
  } state_e;

endpackage

// File: rtl/alu_with_extra_op.sv
// Shared 16-bit ALU used beside the sequencer.
// Carry is the adder carry for ADD and the borrow for SUB.
module alu_with_extra_op
  import alu_op_sequencer_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [2:0]  alu_op,
  output logic [15:0] result,
  output logic        zero,
  output logic        carry_out
);

  logic [16:0] wide;
  logic [31:0] rot;

  always_comb begin
    wide      = 17'd0;
    rot       = {a, a} >> b[3:0];
    result    = 16'd0;
    carry_out = 1'b0;
    case (alu_op)
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_ADD: begin
        wide      = {1'b0, a} + {1'b0, b};
        result    = wide[15:0];
        carry_out = wide[16];
      end
      ALU_XOR:  result = a ^ b;
      ALU_SLLI: result = a << b[3:0];
      ALU_ROR:  result = rot[15:0];
      ALU_SUB: begin
        wide      = {1'b0, a} - {1'b0, b};
        result    = wide[15:0];
        carry_out = wide[16];
      end
      default:  result = 16'd0;
    endcase
    zero = (result == 16'd0);
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Drives the shared ALU for single ops and a
// 16-step shift-add multiply over valid/ready.
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int ITER_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [3:0]           cmd_op,
  input  logic [WIDTH-1:0]     cmd_a,
  input  logic [WIDTH-1:0]     cmd_b,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [2*WIDTH-1:0]   resp_result,
  output logic                 resp_zero,
  output logic                 resp_carry,
  output logic                 resp_err,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  output logic [2:0]           alu_op,
  input  logic [WIDTH-1:0]     alu_result,
  input  logic                 alu_zero,
  input  logic                 alu_carry
);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [2:0]           op_q, op_d;
  logic [WIDTH-1:0]     phi_q, phi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic [ITER_W-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   res_q, res_d;
  logic                 zero_q, zero_d;
  logic                 carry_q, carry_d;
  logic                 err_q, err_d;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    phi_d   = phi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          a_d   = cmd_a;
          b_d   = cmd_b;
          op_d  = cmd_op[2:0];
          err_d = 1'b0;
          if (!cmd_op[3]) begin
            state_d = S_EXEC;
          end else if (cmd_op == CMD_MUL) begin
            state_d = S_MUL_IT;
            phi_d   = '0;
            lo_d    = cmd_b;
            cnt_d   = '0;
          end else begin
            state_d = S_DONE;
            err_d   = 1'b1;
            res_d   = '0;
            zero_d  = 1'b0;
            carry_d = 1'b0;
          end
        end
      end
      S_EXEC: begin
        res_d   = {{WIDTH{1'b0}}, alu_result};
        zero_d  = alu_zero;
        carry_d = alu_carry;
        state_d = S_DONE;
      end
      S_MUL_IT: begin
        // Adder carry becomes the new top bit as the pair shifts right.
        {phi_d, lo_d} = {alu_carry, alu_result, lo_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) begin
          state_d = S_DONE;
          res_d   = {phi_d, lo_d};
          zero_d  = ({phi_d, lo_d} == '0);
          carry_d = 1'b0;
        end
      end
      S_DONE: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      phi_q   <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      phi_q   <= phi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = 3'b000;
    unique case (state_q)
      S_EXEC: begin
        alu_a  = a_q;
        alu_b  = b_q;
        alu_op = op_q;
      end
      S_MUL_IT: begin
        alu_a  = phi_q;
        alu_b  = lo_q[0] ? a_q : '0;
        alu_op = ALU_ADD;
      end
      default: begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = 3'b000;
      end
    endcase
  end

  assign cmd_ready   = (state_q == S_IDLE);
  assign resp_valid  = (state_q == S_DONE);
  assign resp_result = res_q;
  assign resp_zero   = zero_q;
  assign resp_carry  = carry_q;
  assign resp_err    = err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for the sequencer plus ALU pair.
// Directed plan, then random commands vs a reference model.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [15:0] cmd_a;
  logic [15:0] cmd_b;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_result;
  logic        resp_zero;
  logic        resp_carry;
  logic        resp_err;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [2:0]  alu_op;
  logic [15:0] alu_result;
  logic        alu_zero;
  logic        alu_carry;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_op_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_a       (cmd_a),
    .cmd_b       (cmd_b),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .resp_zero   (resp_zero),
    .resp_carry  (resp_carry),
    .resp_err    (resp_err),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .alu_result  (alu_result),
    .alu_zero    (alu_zero),
    .alu_carry   (alu_carry)
  );

  alu_with_extra_op u_alu (
    .a         (alu_a),
    .b         (alu_b),
    .alu_op    (alu_op),
    .result    (alu_result),
    .zero      (alu_zero),
    .carry_out (alu_carry)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  // Expected response and latency (negedges after accept)
  function automatic void model(
    input  logic [3:0]  op,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [31:0] r,
    output logic        z,
    output logic        c,
    output logic        e,
    output int          lat);
    int unsigned s;
    int unsigned x;
    int          d;
    s = b[3:0];
    c = 1'b0;
    e = 1'b0;
    r = 32'd0;
    if (op == 4'b1000) begin
      r   = 32'(a) * 32'(b);
      lat = 16;
    end else if (op[3]) begin
      e   = 1'b1;
      lat = 0;
    end else begin
      lat = 1;
      case (op[2:0])
        3'd0: r = a & b;
        3'd1: r = a | b;
        3'd2: begin
          x = a + b;
          r = x % 65536;
          c = (x > 65535);
        end
        3'd3: r = a ^ b;
        3'd4: r = (a * (2 ** s)) % 65536;
        3'd5: r = ((a / (2 ** s)) +
                   (a * (2 ** (16 - s)))) % 65536;
        3'd6: begin
          d = int'(a) - int'(b);
          c = (d < 0);
          r = (d + 65536) % 65536;
        end
        default: r = 32'd0;
      endcase
    end
    if (!e) z = (r == 32'd0);
    else    z = 1'b0;
  endfunction

  task automatic run_cmd(input logic [3:0]  op,
                         input logic [15:0] a,
                         input logic [15:0] b,
                         input int          hold,
                         input bit          early);
    logic [31:0] er;
    logic        ez, ec, ee;
    int          el;
    int          lat;
    model(op, a, b, er, ez, ec, ee, el);
    @(negedge clk);
    chk("idle_ready", cmd_ready, 1);
    chk("idle_alu_a", alu_a, 0);
    cmd_valid  = 1'b1;
    cmd_op     = op;
    cmd_a      = a;
    cmd_b      = b;
    resp_ready = early;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    if (!op[3]) begin
      chk("exec_alu_a", alu_a, a);
      chk("exec_alu_b", alu_b, b);
      chk("exec_alu_op", alu_op, op[2:0]);
    end else if (op == 4'b1000) begin
      chk("mul_alu_op", alu_op, 3'b010);
      chk("mul_alu_a", alu_a, 0);
      chk("mul_alu_b", alu_b, b[0] ? a : 16'd0);
    end
    lat = 0;
    while (!resp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, el);
    chk("result", resp_result, er);
    chk("zero", resp_zero, ez);
    chk("carry", resp_carry, ec);
    chk("err", resp_err, ee);
    if (!early) begin
      for (int i = 0; i < hold; i++) begin
        cmd_valid = 1'b1;
        cmd_op    = 4'($urandom_range(0, 15));
        @(negedge clk);
        chk("hold_valid", resp_valid, 1);
        chk("hold_result", resp_result, er);
        chk("hold_ready", cmd_ready, 0);
      end
      resp_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    cmd_valid  = 1'b0;
    chk("post_valid", resp_valid, 0);
    chk("post_ready", cmd_ready, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int vcount;
    logic [3:0]  rop;
    logic [15:0] ra, rb;
    reset      = 1'b1;
    cmd_valid  = 1'b0;
    cmd_op     = 4'd0;
    cmd_a      = 16'd0;
    cmd_b      = 16'd0;
    resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_valid", resp_valid, 0);
    chk("rst_result", resp_result, 0);
    chk("rst_flags", {resp_zero, resp_carry, resp_err}, 0);
    chk("rst_alu", {alu_a, alu_b}, 0);
    chk("rst_alu_op", alu_op, 0);
    reset = 1'b0;

    run_cmd(4'b0000, 16'd6, 16'd3, 0, 1'b0);
    run_cmd(4'b0010, 16'd10, 16'd40, 0, 1'b0);
    run_cmd(4'b0110, 16'd10, 16'd10, 0, 1'b0);
    run_cmd(4'b0110, 16'd40, 16'd30, 0, 1'b0);
    run_cmd(4'b1000, 16'd300, 16'd500, 0, 1'b0);
    run_cmd(4'b1000, 16'hFFFF, 16'hFFFF, 0, 1'b0);
    run_cmd(4'b1000, 16'd1234, 16'd0, 0, 1'b0);
    run_cmd(4'b0101, 16'd6, 16'd3, 5, 1'b0);
    run_cmd(4'b0010, 16'd7, 16'd8, 0, 1'b1);

    // Abandon a multiply at iteration 7
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 4'b1000;
    cmd_a     = 16'd300;
    cmd_b     = 16'd500;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("mrst_ready", cmd_ready, 1);
    chk("mrst_valid", resp_valid, 0);
    chk("mrst_result", resp_result, 0);
    chk("mrst_flags", {resp_zero, resp_carry, resp_err}, 0);
    chk("mrst_alu", {alu_a, alu_b}, 0);
    chk("mrst_alu_op", alu_op, 0);
    vcount = 0;
    repeat (20) begin
      @(negedge clk);
      if (resp_valid) vcount++;
    end
    chk("mrst_no_resp", vcount, 0);
    run_cmd(4'b0010, 16'd1, 16'd1, 0, 1'b0);

    run_cmd(4'b1011, 16'd55, 16'd66, 2, 1'b0);
    run_cmd(4'b0001, 16'h00F0, 16'h0F00, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      rop = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) rop = 4'b1000;
      ra = 16'($urandom);
      rb = 16'($urandom);
      if ($urandom_range(0, 7) == 0) ra = 16'hFFFF;
      if ($urandom_range(0, 7) == 0) rb = 16'd0;
      run_cmd(rop, ra, rb, $urandom_range(0, 3),
              1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Sequences the shared 16-bit ALU (ops AND/OR/ADD/XOR/SLLI/ROR/SUB) for the CPU's multi-cycle execute path.
- Accepts one command at a time over a valid/ready handshake and drives the ALU's A, B and ALUOp inputs.
- Single ALU ops are issued once and the result registered.
- MUL is performed as a 16-iteration shift-add that reuses the ALU ADD path, producing a 32-bit product without a dedicated multiplier.

Parameters:
WIDTH, 16, operand width; only 16 is supported and verified.
ITER_W, 4, iteration counter width; must satisfy 2**ITER_W == WIDTH.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept; high only in IDLE
cmd_op  input  4  bit3=0: ALU op in bits[2:0]; 4'b1000: MUL; 4'b1001..4'b1111: reserved
cmd_a  input  16  operand A / multiplicand
cmd_b  input  16  operand B / multiplier
resp_valid  output  1  result available; held until accepted
resp_ready  input  1  consumer accepts result
resp_result  output  32  {16'b0, ALU result} for ALU ops; full product for MUL
resp_zero  output  1  ALU Zero for ALU ops; (product==0) for MUL
resp_carry  output  1  ALU CarryOut for ALU ops; 0 for MUL
resp_err  output  1  reserved opcode
alu_a  output  16  to ALU A
alu_b  output  16  to ALU B
alu_op  output  3  to ALU ALUOp
alu_result  input  16  from ALU Result
alu_zero  input  1  from ALU Zero
alu_carry  input  1  from ALU CarryOut

Behaviour:
- Reset (sync, highest priority, legal in any state):
  - state=IDLE; cmd_ready=1.
  - resp_valid=0, resp_result=0, resp_zero=0, resp_carry=0, resp_err=0.
  - Internal registers and the iteration counter are cleared.
  - alu_a/alu_b/alu_op = 0.
  - An in-flight MUL is abandoned and produces no response.
- Handshake:
  - A command is accepted on a cycle with cmd_valid && cmd_ready.
  - Operands and opcode are latched on acceptance.
  - cmd_ready=0 outside IDLE; cmd_valid in other states is ignored.
  - A response completes on a cycle with resp_valid && resp_ready.
- States:
  - IDLE
    - ALU inputs are driven 0.
    - On accept: ALU op -> EXEC; MUL -> MUL_IT with P_hi=0, lo=cmd_b, cnt=0; reserved -> DONE with resp_err=1 and resp_result=0.
  - EXEC (1 cycle)
    - Drive alu_a/alu_b/alu_op from the latched command.
    - Capture alu_result, alu_zero and alu_carry into the resp registers, then -> DONE.
  - MUL_IT (16 cycles)
    - Drive alu_op=3'b010 (ADD), alu_a=P_hi, alu_b = lo[0] ? mcand : 16'h0.
    - Each cycle, {P_hi, lo} <= {alu_carry, alu_result, lo[15:1]}; cnt <= cnt+1.
    - When cnt==15 -> DONE with resp_result={P_hi_next, lo_next}, resp_zero=(product==0), resp_carry=0.
  - DONE
    - resp_valid=1; all resp_* outputs stable.
    - On resp_ready -> IDLE; resp_valid drops the next cycle.
- Latency from the acceptance edge T:
  - ALU op: resp_valid at T+2.
  - MUL: resp_valid at T+17.
  - Reserved: resp_valid at T+1.
- Boundaries:
  - resp_ready asserted before resp_valid has no effect.
  - A new command cannot be accepted in the same cycle as response completion (cmd_ready only in IDLE).
  - Multiplier 0 still runs all 16 iterations.
  - 0xFFFF*0xFFFF requires carry capture on every add.
- Arithmetic is unsigned; the product is exact in 32 bits.

Decomposition:
- Shared package holds:
  - ALU opcode constants: AND=000, OR=001, ADD=010, XOR=011, SLLI=100, ROR=101, SUB=110.
  - CMD_MUL=4'b1000.
  - The state encoding (IDLE, EXEC, MUL_IT, DONE).
- Single module; the ALU itself stays external (ALU_with_extra_OP) and is instantiated beside the sequencer at datapath level.
- The bench instantiates both together.

Test Plan:
1. AND, then ADD: cmd_op=0000, A=6, B=3 -> resp_result=2 at T+2; then cmd_op=0010, A=10, B=40 -> resp_result=50, resp_zero=0.
2. SUB zero/nonzero: cmd_op=0110, A=10, B=10 -> resp_result=0, resp_zero=1; then A=40, B=30 -> resp_result=10, resp_zero=0.
3. MUL: cmd_op=1000, A=300, B=500 -> resp_result=150000 at T+17, resp_carry=0; then A=0xFFFF, B=0xFFFF -> 0xFFFE0001; then A=1234, B=0 -> 0 with resp_zero=1.
4. Backpressure: hold resp_ready=0 for 5 cycles after ROR, A=6, B=3 -> resp_valid and resp_result stay stable, cmd_ready=0 throughout, and a second cmd_valid is not accepted until after the handshake.
5. Reset mid-MUL: assert reset at iteration 7 for 1 cycle -> next cycle IDLE, cmd_ready=1, all resp_* and alu_* = 0; the following ADD 1+1 -> resp_result=2.
6. Reserved opcode: cmd_op=1011 -> resp_err=1, resp_result=0 at T+1; the next legal command returns resp_err=0.
